// File: rtl/uart_cmd_if.sv
// UART command front end: deserialises host frames into register-bus strobes
// and serialises read data back to the host at a register-selected baud rate.
module uart_cmd_if #(
    parameter int BASE_DIV     = 16,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic       rst_n,
    input  logic       clk_i,
    input  logic       uart_rx_i,
    input  logic [2:0] baud_sel_i,
    input  logic [7:0] cmd_rdata_i,
    output logic [7:0] cmd_addr_o,
    output logic [7:0] cmd_data_o,
    output logic       cmd_wr_o,
    output logic       cmd_rd_o,
    output logic       uart_tx_o,
    output logic       frame_err_o
);

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    localparam logic [2:0] P_HDR     = 3'd0;
    localparam logic [2:0] P_ADDR    = 3'd1;
    localparam logic [2:0] P_DATA    = 3'd2;
    localparam logic [2:0] P_RD_WAIT = 3'd3;
    localparam logic [2:0] P_RD_CAP  = 3'd4;

    localparam logic [1:0] T_IDLE  = 2'd0;
    localparam logic [1:0] T_START = 2'd1;
    localparam logic [1:0] T_DATA  = 2'd2;
    localparam logic [1:0] T_STOP  = 2'd3;

    localparam logic [7:0] HDR_WR = 8'hA5;
    localparam logic [7:0] HDR_RD = 8'h5A;

    function automatic logic [15:0] bit_period(input logic [2:0] sel);
        bit_period = 16'(BASE_DIV) << (3'd7 - sel);
    endfunction

    logic        rx_meta_p0, rx_sync_p1, rx_prev_p2;
    logic [1:0]  rx_state;
    logic [15:0] rx_cnt, rx_per;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_sh;
    logic        rx_fall, rx_hit_half, rx_hit_full, byte_vld, stop_err;

    logic [2:0]  p_state;
    logic        wr_flag;
    logic [15:0] to_cyc, to_bits;
    logic        to_active, timeout, hdr_err, tx_drop;
    logic        tx_req;
    logic [7:0]  tx_hold;

    logic [1:0]  tx_state;
    logic [15:0] tx_cnt, tx_per;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_sh;
    logic        tx_line, tx_hit;

    assign rx_fall     = rx_prev_p2 & ~rx_sync_p1;
    assign rx_hit_half = (rx_cnt == (rx_per >> 1) - 16'd1);
    assign rx_hit_full = (rx_cnt == rx_per - 16'd1);
    assign byte_vld    = (rx_state == R_STOP) && rx_hit_full && rx_sync_p1;
    assign stop_err    = (rx_state == R_STOP) && rx_hit_full && !rx_sync_p1;

    // Receive: synchroniser, start qualification at mid-bit, then full-period samples
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
            rx_prev_p2 <= 1'b1;
            rx_state   <= R_IDLE;
            rx_cnt     <= 16'd0;
            rx_per     <= 16'(BASE_DIV);
            rx_bit     <= 3'd0;
        end else begin
            rx_meta_p0 <= uart_rx_i;
            rx_sync_p1 <= rx_meta_p0;
            rx_prev_p2 <= rx_sync_p1;
            case (rx_state)
                R_IDLE: if (rx_fall) begin
                    rx_per   <= bit_period(baud_sel_i);
                    rx_cnt   <= 16'd0;
                    rx_state <= R_START;
                end
                R_START: if (rx_hit_half) begin
                    rx_cnt   <= 16'd0;
                    rx_bit   <= 3'd0;
                    rx_state <= rx_sync_p1 ? R_IDLE : R_DATA;
                end else rx_cnt <= rx_cnt + 16'd1;
                R_DATA: if (rx_hit_full) begin
                    rx_cnt <= 16'd0;
                    rx_bit <= rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state <= R_STOP;
                end else rx_cnt <= rx_cnt + 16'd1;
                R_STOP: if (rx_hit_full) begin
                    rx_cnt   <= 16'd0;
                    rx_state <= R_IDLE;
                end else rx_cnt <= rx_cnt + 16'd1;
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rx_state == R_DATA && rx_hit_full) rx_sh <= {rx_sync_p1, rx_sh[7:1]};
    end

    assign to_active = (p_state == P_ADDR) || (p_state == P_DATA);
    assign timeout   = to_active && !byte_vld && (to_cyc == rx_per - 16'd1) &&
                       (to_bits == 16'(TIMEOUT_BITS - 1));
    assign hdr_err   = (p_state == P_HDR) && byte_vld && (rx_sh != HDR_WR) && (rx_sh != HDR_RD);
    assign tx_drop   = tx_req && (tx_state != T_IDLE);

    // Parse: frame decode, command strobes and inter-byte timeout
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            p_state     <= P_HDR;
            wr_flag     <= 1'b0;
            cmd_addr_o  <= 8'h00;
            cmd_data_o  <= 8'h00;
            cmd_wr_o    <= 1'b0;
            cmd_rd_o    <= 1'b0;
            to_cyc      <= 16'd0;
            to_bits     <= 16'd0;
            tx_req      <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            cmd_wr_o    <= 1'b0;
            cmd_rd_o    <= 1'b0;
            tx_req      <= 1'b0;
            frame_err_o <= stop_err | hdr_err | timeout | tx_drop;
            if (byte_vld || !to_active) begin
                to_cyc  <= 16'd0;
                to_bits <= 16'd0;
            end else if (to_cyc == rx_per - 16'd1) begin
                to_cyc  <= 16'd0;
                to_bits <= to_bits + 16'd1;
            end else to_cyc <= to_cyc + 16'd1;
            if (stop_err || timeout) p_state <= P_HDR;
            else begin
                case (p_state)
                    P_HDR: if (byte_vld) begin
                        if (rx_sh == HDR_WR) begin
                            wr_flag <= 1'b1;
                            p_state <= P_ADDR;
                        end else if (rx_sh == HDR_RD) begin
                            wr_flag <= 1'b0;
                            p_state <= P_ADDR;
                        end
                    end
                    P_ADDR: if (byte_vld) begin
                        cmd_addr_o <= rx_sh;
                        if (wr_flag) p_state <= P_DATA;
                        else begin
                            cmd_rd_o <= 1'b1;
                            p_state  <= P_RD_WAIT;
                        end
                    end
                    P_DATA: if (byte_vld) begin
                        cmd_data_o <= rx_sh;
                        cmd_wr_o   <= 1'b1;
                        p_state    <= P_HDR;
                    end
                    P_RD_WAIT: p_state <= P_RD_CAP;
                    P_RD_CAP: begin
                        tx_req  <= 1'b1;
                        p_state <= P_HDR;
                    end
                    default: p_state <= P_HDR;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (p_state == P_RD_CAP) tx_hold <= cmd_rdata_i;
    end

    assign tx_hit    = (tx_cnt == tx_per - 16'd1);
    assign uart_tx_o = tx_line;

    // Transmit: start, eight data bits LSB first, stop
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= T_IDLE;
            tx_line  <= 1'b1;
            tx_cnt   <= 16'd0;
            tx_per   <= 16'(BASE_DIV);
            tx_bit   <= 3'd0;
        end else begin
            tx_cnt <= tx_hit ? 16'd0 : tx_cnt + 16'd1;
            case (tx_state)
                T_IDLE: begin
                    tx_cnt <= 16'd0;
                    if (tx_req) begin
                        tx_per   <= bit_period(baud_sel_i);
                        tx_line  <= 1'b0;
                        tx_state <= T_START;
                    end
                end
                T_START: if (tx_hit) begin
                    tx_line  <= tx_sh[0];
                    tx_bit   <= 3'd0;
                    tx_state <= T_DATA;
                end
                T_DATA: if (tx_hit) begin
                    tx_bit <= tx_bit + 3'd1;
                    if (tx_bit == 3'd7) begin
                        tx_line  <= 1'b1;
                        tx_state <= T_STOP;
                    end else tx_line <= tx_sh[1];
                end
                T_STOP: if (tx_hit) tx_state <= T_IDLE;
                default: tx_state <= T_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (tx_state == T_IDLE && tx_req) tx_sh <= tx_hold;
        else if (tx_state == T_DATA && tx_hit) tx_sh <= tx_sh >> 1;
    end

endmodule

// File: tb/tb_uart_cmd_if.sv
// Directed bench for uart_cmd_if: host-side UART driver, register-block model
// and a TX decoder; all checks live in the main initial block.
module tb_uart_cmd_if;

    logic       clk_i = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rx_i = 1'b1;
    logic [2:0] baud_sel;
    logic [7:0] cmd_rdata;
    logic [7:0] cmd_addr_o, cmd_data_o;
    logic       cmd_wr_o, cmd_rd_o, uart_tx_o, frame_err_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, rd_cyc = 0;
    logic [7:0] wr_addr = 8'h00, wr_data = 8'h00;
    int tx_cnt = 0, tx_fall_cyc = 0;
    logic [7:0] tx_byte = 8'h00;
    logic tx_start_bit = 1'b1, tx_stop_bit = 1'b0;
    int tb_per = 64;
    int w0, r0, e0, t0;

    uart_cmd_if #(.BASE_DIV(16), .TIMEOUT_BITS(20)) dut (
        .rst_n      (rst_n),
        .clk_i      (clk_i),
        .uart_rx_i  (uart_rx_i),
        .baud_sel_i (baud_sel),
        .cmd_rdata_i(cmd_rdata),
        .cmd_addr_o (cmd_addr_o),
        .cmd_data_o (cmd_data_o),
        .cmd_wr_o   (cmd_wr_o),
        .cmd_rd_o   (cmd_rd_o),
        .uart_tx_o  (uart_tx_o),
        .frame_err_o(frame_err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Register block model: read data = addr + 3, one cycle after the strobe;
    // a write to address 0x03 retunes the baud field.
    always @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            baud_sel  <= 3'd5;
            cmd_rdata <= 8'h00;
        end else begin
            if (cmd_rd_o) cmd_rdata <= cmd_addr_o + 8'h03;
            if (cmd_wr_o && cmd_addr_o == 8'h03) baud_sel <= cmd_data_o[2:0];
        end
    end

    always @(negedge clk_i) begin
        if (cmd_wr_o) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= cmd_addr_o;
            wr_data <= cmd_data_o;
        end
        if (cmd_rd_o) begin
            rd_cnt <= rd_cnt + 1;
            rd_cyc <= cyc;
        end
        if (frame_err_o) err_cnt <= err_cnt + 1;
    end

    initial begin
        logic prev_tx;
        logic [7:0] bits;
        prev_tx = 1'b1;
        forever begin
            @(negedge clk_i);
            if (prev_tx && !uart_tx_o) begin
                tx_fall_cyc = cyc;
                repeat (tb_per / 2) @(negedge clk_i);
                tx_start_bit = uart_tx_o;
                for (int i = 0; i < 8; i++) begin
                    repeat (tb_per) @(negedge clk_i);
                    bits[i] = uart_tx_o;
                end
                repeat (tb_per) @(negedge clk_i);
                tx_stop_bit = uart_tx_o;
                tx_byte = bits;
                tx_cnt++;
            end
            prev_tx = uart_tx_o;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_hi, input int per);
        @(negedge clk_i);
        uart_rx_i = 1'b0;
        repeat (per) @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            repeat (per) @(negedge clk_i);
        end
        uart_rx_i = stop_hi;
        repeat (per) @(negedge clk_i);
        uart_rx_i = 1'b1;
    endtask

    task automatic snap();
        w0 = wr_cnt;
        r0 = rd_cnt;
        e0 = err_cnt;
        t0 = tx_cnt;
    endtask

    initial begin
        idle(4);
        chk("rst_addr", cmd_addr_o, 8'h00);
        chk("rst_data", cmd_data_o, 8'h00);
        chk("rst_wr", cmd_wr_o, 1'b0);
        chk("rst_rd", cmd_rd_o, 1'b0);
        chk("rst_tx", uart_tx_o, 1'b1);
        chk("rst_err", frame_err_o, 1'b0);
        rst_n = 1'b1;
        idle(10);

        // Write frame at P=64
        snap();
        send_byte(8'hA5, 1'b1, 64);
        send_byte(8'h02, 1'b1, 64);
        send_byte(8'h01, 1'b1, 64);
        idle(128);
        chk("wr_count", wr_cnt - w0, 1);
        chk("wr_addr", wr_addr, 8'h02);
        chk("wr_data", wr_data, 8'h01);
        chk("wr_no_rd", rd_cnt - r0, 0);
        chk("wr_no_err", err_cnt - e0, 0);

        // Read frame at P=64, model returns 0x05
        snap();
        tb_per = 64;
        send_byte(8'h5A, 1'b1, 64);
        send_byte(8'h02, 1'b1, 64);
        for (int i = 0; i < 3000 && tx_cnt == t0; i++) idle(1);
        chk("rd_tx_done", tx_cnt - t0, 1);
        chk("rd_count", rd_cnt - r0, 1);
        chk("rd_tx_byte", tx_byte, 8'h05);
        chk("rd_tx_start", tx_start_bit, 1'b0);
        chk("rd_tx_stop", tx_stop_bit, 1'b1);
        chk("rd_to_tx_lat", tx_fall_cyc - rd_cyc, 3);
        chk("rd_no_err", err_cnt - e0, 0);
        chk("rd_data_hold", cmd_data_o, 8'h01);

        // Bad header
        idle(64);
        snap();
        send_byte(8'h33, 1'b1, 64);
        idle(128);
        chk("hdr_err", err_cnt - e0, 1);
        chk("hdr_no_wr", wr_cnt - w0, 0);
        chk("hdr_no_rd", rd_cnt - r0, 0);

        // Stop bit low on the address byte, then a clean frame
        snap();
        send_byte(8'hA5, 1'b1, 64);
        send_byte(8'h02, 1'b0, 64);
        idle(128);
        chk("stop_err", err_cnt - e0, 1);
        chk("stop_no_wr", wr_cnt - w0, 0);
        chk("stop_addr_hold", cmd_addr_o, 8'h02);
        snap();
        send_byte(8'hA5, 1'b1, 64);
        send_byte(8'h04, 1'b1, 64);
        send_byte(8'h09, 1'b1, 64);
        idle(128);
        chk("stop_recover_wr", wr_cnt - w0, 1);
        chk("stop_recover_addr", wr_addr, 8'h04);
        chk("stop_recover_data", wr_data, 8'h09);
        chk("stop_recover_err", err_cnt - e0, 0);

        // Inter-byte timeout after a read header
        snap();
        send_byte(8'h5A, 1'b1, 64);
        idle(20 * 64 + 40);
        chk("timeout_err", err_cnt - e0, 1);
        chk("timeout_no_rd", rd_cnt - r0, 0);
        snap();
        send_byte(8'hA5, 1'b1, 64);
        send_byte(8'h06, 1'b1, 64);
        send_byte(8'h0A, 1'b1, 64);
        idle(128);
        chk("timeout_recover_wr", wr_cnt - w0, 1);
        chk("timeout_recover_addr", wr_addr, 8'h06);
        chk("timeout_recover_err", err_cnt - e0, 0);

        // 10-cycle glitch is a false start
        snap();
        @(negedge clk_i);
        uart_rx_i = 1'b0;
        idle(10);
        uart_rx_i = 1'b1;
        idle(300);
        chk("glitch_no_err", err_cnt - e0, 0);
        chk("glitch_no_wr", wr_cnt - w0, 0);

        // Baud change to sel=7 (P=16), then frames at the new rate
        snap();
        send_byte(8'hA5, 1'b1, 64);
        send_byte(8'h03, 1'b1, 64);
        send_byte(8'h07, 1'b1, 64);
        idle(64);
        chk("baud_wr_data", wr_data, 8'h07);
        chk("baud_sel_now", baud_sel, 3'd7);
        snap();
        send_byte(8'hA5, 1'b1, 16);
        send_byte(8'h08, 1'b1, 16);
        send_byte(8'h0C, 1'b1, 16);
        idle(64);
        chk("fast_wr_count", wr_cnt - w0, 1);
        chk("fast_wr_addr", wr_addr, 8'h08);
        chk("fast_wr_data", wr_data, 8'h0C);
        chk("fast_no_err", err_cnt - e0, 0);
        snap();
        tb_per = 16;
        send_byte(8'h5A, 1'b1, 16);
        send_byte(8'h02, 1'b1, 16);
        for (int i = 0; i < 1000 && tx_cnt == t0; i++) idle(1);
        chk("fast_tx_done", tx_cnt - t0, 1);
        chk("fast_tx_byte", tx_byte, 8'h05);
        chk("fast_rd_to_tx_lat", tx_fall_cyc - rd_cyc, 3);

        // Reset while TX is driving a low bit forces the line high at once
        idle(32);
        send_byte(8'h5A, 1'b1, 16);
        send_byte(8'h02, 1'b1, 16);
        for (int i = 0; i < 200 && uart_tx_o !== 1'b0; i++) idle(1);
        chk("midtx_low", uart_tx_o, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midtx_async_high", uart_tx_o, 1'b1);
        chk("midtx_addr_rst", cmd_addr_o, 8'h00);
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
